// File: rtl/axis_mm2s_cmd_throttle.sv
// axis_mm2s_cmd_throttle
// Forwards 72-bit DataMover MM2S commands through a one-deep register slice,
// stamping each with a rolling 4-bit tag in bits [67:64]. A credit counter
// bounds the number of commands the DataMover holds without a returned status.
// The status stream is consumed and checked against the oldest expected tag.
// The first error (bad status bits, tag mismatch or a status with nothing
// outstanding) is latched and stops new commands until software pulses clear.

module axis_mm2s_cmd_throttle #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic [71:0]      s_axis_cmd_tdata,
    input  logic             s_axis_cmd_tvalid,
    output logic             s_axis_cmd_tready,
    input  logic             s_axis_cmd_tlast,

    output logic [71:0]      m_axis_cmd_tdata,
    output logic             m_axis_cmd_tvalid,
    input  logic             m_axis_cmd_tready,
    output logic             m_axis_cmd_tlast,

    input  logic [7:0]       s_axis_sts_tdata,
    input  logic             s_axis_sts_tvalid,
    output logic             s_axis_sts_tready,

    input  logic             clear,
    output logic [OUT_W-1:0] outstanding,
    output logic [31:0]      cmd_count,
    output logic [31:0]      sts_count,
    output logic             err_flag,
    output logic [7:0]       err_code
);

    // Credit limit widened by one bit so the in-flight sum cannot overflow.
    localparam logic [OUT_W:0] MAX_CREDIT = (OUT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [7:0]     PROTO_ERR  = 8'hFF;

    // Register slice
    logic [71:0]      m_tdata_q,     m_tdata_d;
    logic             m_tvalid_q,    m_tvalid_d;
    logic [3:0]       tag_q,         tag_d;

    // Status tracking
    logic [3:0]       exp_tag_q,     exp_tag_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;

    // Statistics and error state
    logic [31:0]      cmd_count_q,   cmd_count_d;
    logic [31:0]      sts_count_q,   sts_count_d;
    logic             err_flag_q,    err_flag_d;
    logic [7:0]       err_code_q,    err_code_d;

    // Handshakes and status classification
    logic             s_hs;
    logic             m_hs;
    logic             st_hs;
    logic             st_valid;
    logic             sts_orphan;
    logic             sts_bad;
    logic             new_err;
    logic             credit_ok;
    logic [OUT_W:0]   credit_used;

    // The generator's tlast carries no meaning for single-beat commands.
    logic             unused_tlast;
    assign unused_tlast = s_axis_cmd_tlast;

    // A command sitting in the slice already holds a credit, so it is counted
    // alongside the commands the DataMover has accepted.
    assign credit_used = {1'b0, outstanding_q} + {{OUT_W{1'b0}}, m_tvalid_q};
    assign credit_ok   = (credit_used < MAX_CREDIT);

    assign s_axis_cmd_tready = resetn & ~err_flag_q & ~clear
                             & (~m_tvalid_q | m_axis_cmd_tready) & credit_ok;
    assign s_axis_sts_tready = resetn;

    assign s_hs  = s_axis_cmd_tvalid & s_axis_cmd_tready;
    assign m_hs  = m_tvalid_q & m_axis_cmd_tready;
    assign st_hs = s_axis_sts_tvalid & s_axis_sts_tready;

    // A status with nothing outstanding has no command to match against.
    assign sts_orphan = (outstanding_q == '0);
    assign st_valid   = st_hs & ~sts_orphan;
    assign sts_bad    = ~s_axis_sts_tdata[7]
                      | (|s_axis_sts_tdata[6:4])
                      | (s_axis_sts_tdata[3:0] != exp_tag_q);
    assign new_err    = st_hs & (sts_orphan | sts_bad);

    // Next-state computation for the slice, counters and error latch.
    always_comb begin
        m_tdata_d     = m_tdata_q;
        m_tvalid_d    = m_tvalid_q;
        tag_d         = tag_q;
        exp_tag_d     = exp_tag_q;
        outstanding_d = outstanding_q;
        cmd_count_d   = cmd_count_q;
        sts_count_d   = sts_count_q;
        err_flag_d    = err_flag_q;
        err_code_d    = err_code_q;

        if (s_hs) begin
            m_tdata_d  = {s_axis_cmd_tdata[71:68], tag_q, s_axis_cmd_tdata[63:0]};
            m_tvalid_d = 1'b1;
            tag_d      = tag_q + 4'd1;
        end else if (m_hs) begin
            m_tvalid_d = 1'b0;
        end

        if (m_hs) begin
            cmd_count_d = cmd_count_q + 32'd1;
        end

        unique case ({m_hs, st_valid})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (st_valid) begin
            exp_tag_d = exp_tag_q + 4'd1;
        end

        if (st_hs) begin
            sts_count_d = sts_count_q + 32'd1;
        end

        if (new_err && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_code_d = sts_orphan ? PROTO_ERR : s_axis_sts_tdata;
        end

        // Soft clear leaves tags, credit and the slice alone so statuses for
        // commands already in flight still line up afterwards.
        if (clear) begin
            err_flag_d  = 1'b0;
            err_code_d  = 8'h00;
            cmd_count_d = 32'd0;
            sts_count_d = 32'd0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_tdata_q     <= 72'd0;
            m_tvalid_q    <= 1'b0;
            tag_q         <= 4'd0;
            exp_tag_q     <= 4'd0;
            outstanding_q <= '0;
            cmd_count_q   <= 32'd0;
            sts_count_q   <= 32'd0;
            err_flag_q    <= 1'b0;
            err_code_q    <= 8'h00;
        end else begin
            m_tdata_q     <= m_tdata_d;
            m_tvalid_q    <= m_tvalid_d;
            tag_q         <= tag_d;
            exp_tag_q     <= exp_tag_d;
            outstanding_q <= outstanding_d;
            cmd_count_q   <= cmd_count_d;
            sts_count_q   <= sts_count_d;
            err_flag_q    <= err_flag_d;
            err_code_q    <= err_code_d;
        end
    end

    assign m_axis_cmd_tdata  = m_tdata_q;
    assign m_axis_cmd_tvalid = m_tvalid_q;
    assign m_axis_cmd_tlast  = 1'b1;
    assign outstanding       = outstanding_q;
    assign cmd_count         = cmd_count_q;
    assign sts_count         = sts_count_q;
    assign err_flag          = err_flag_q;
    assign err_code          = err_code_q;

endmodule

// File: tb/tb_axis_mm2s_cmd_throttle.sv
// Testbench for axis_mm2s_cmd_throttle with MAX_OUTSTANDING = 4.
// A table of per-cycle vectors covers forwarding, credit and stall behaviour;
// hand-written sequences cover tag wrap, error latching and soft clear.

module tb_axis_mm2s_cmd_throttle;

    logic        clk = 1'b0;
    logic        resetn;
    logic [71:0] s_axis_cmd_tdata;
    logic        s_axis_cmd_tvalid;
    logic        s_axis_cmd_tready;
    logic        s_axis_cmd_tlast;
    logic [71:0] m_axis_cmd_tdata;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready;
    logic        m_axis_cmd_tlast;
    logic [7:0]  s_axis_sts_tdata;
    logic        s_axis_sts_tvalid;
    logic        s_axis_sts_tready;
    logic        clear;
    logic [2:0]  outstanding;
    logic [31:0] cmd_count;
    logic [31:0] sts_count;
    logic        err_flag;
    logic [7:0]  err_code;

    int          nChecks = 0;
    int          nFail   = 0;
    logic [3:0]  tagM;
    logic [3:0]  expM;

    axis_mm2s_cmd_throttle #(.MAX_OUTSTANDING(4)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .s_axis_cmd_tdata  (s_axis_cmd_tdata),
        .s_axis_cmd_tvalid (s_axis_cmd_tvalid),
        .s_axis_cmd_tready (s_axis_cmd_tready),
        .s_axis_cmd_tlast  (s_axis_cmd_tlast),
        .m_axis_cmd_tdata  (m_axis_cmd_tdata),
        .m_axis_cmd_tvalid (m_axis_cmd_tvalid),
        .m_axis_cmd_tready (m_axis_cmd_tready),
        .m_axis_cmd_tlast  (m_axis_cmd_tlast),
        .s_axis_sts_tdata  (s_axis_sts_tdata),
        .s_axis_sts_tvalid (s_axis_sts_tvalid),
        .s_axis_sts_tready (s_axis_sts_tready),
        .clear             (clear),
        .outstanding       (outstanding),
        .cmd_count         (cmd_count),
        .sts_count         (sts_count),
        .err_flag          (err_flag),
        .err_code          (err_code)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    typedef struct {
        logic       cmdV;
        int         cmdI;
        logic       mRdy;
        logic       stsV;
        logic [7:0] stsD;
        logic       eSRdy;
        logic       eMV;
        int         eDi;
        logic [3:0] eTag;
        int         eOut;
        int         eCc;
        int         eSc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cv, input int ci, input logic mr,
                                input logic sv, input logic [7:0] sd,
                                input logic esr, input logic emv, input int edi,
                                input logic [3:0] etag, input int eout,
                                input int ecc, input int esc);
        vec_t v;
        v.cmdV = cv;  v.cmdI = ci;  v.mRdy = mr;  v.stsV = sv;  v.stsD = sd;
        v.eSRdy = esr; v.eMV = emv; v.eDi = edi;  v.eTag = etag;
        v.eOut = eout; v.eCc = ecc; v.eSc = esc;
        return v;
    endfunction

    // Command word with a poison value in the tag field that must be replaced.
    function automatic logic [71:0] cmdWord(input int i);
        return {4'h5, 4'hF, 32'hC0DE_0000, 32'(i)};
    endfunction

    function automatic logic [71:0] expWord(input int i, input logic [3:0] tag);
        return {4'h5, tag, 32'hC0DE_0000, 32'(i)};
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] act,
                               input logic [71:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge, then move to the
    // sampling point in the middle of the cycle.
    task automatic applyStimulus(input logic cv, input logic [71:0] cd,
                                 input logic mr, input logic sv,
                                 input logic [7:0] sd, input logic clr);
        s_axis_cmd_tvalid = cv;
        s_axis_cmd_tdata  = cd;
        m_axis_cmd_tready = mr;
        s_axis_sts_tvalid = sv;
        s_axis_sts_tdata  = sd;
        clear             = clr;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command, then watch it leave the slice with the next tag.
    task automatic issueCmd(input int idx);
        applyStimulus(1'b1, cmdWord(idx), 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput($sformatf("cmd%0d s_tready", idx), 72'(s_axis_cmd_tready), 72'(1));
        tick();
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput($sformatf("cmd%0d m_tvalid", idx), 72'(m_axis_cmd_tvalid), 72'(1));
        checkOutput($sformatf("cmd%0d m_tdata", idx), m_axis_cmd_tdata, expWord(idx, tagM));
        tick();
        tagM = tagM + 4'd1;
    endtask

    task automatic returnSts(input logic [7:0] sd);
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b1, sd, 1'b0);
        tick();
    endtask

    task automatic checkErr(input string name, input logic ef, input logic [7:0] ec);
        checkOutput({name, " err_flag"}, 72'(err_flag), 72'(ef));
        checkOutput({name, " err_code"}, 72'(err_code), 72'(ec));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_axis_cmd_tlast = 1'b0;
        resetn = 1'b0;
        applyStimulus(1'b1, cmdWord(99), 1'b1, 1'b1, 8'h80, 1'b0);
        repeat (3) tick();
        #3;
        checkOutput("rst s_tready",   72'(s_axis_cmd_tready), 72'(0));
        checkOutput("rst sts_tready", 72'(s_axis_sts_tready), 72'(0));
        checkOutput("rst m_tvalid",   72'(m_axis_cmd_tvalid), 72'(0));
        checkOutput("rst m_tdata",    m_axis_cmd_tdata, 72'd0);
        checkOutput("rst outstanding", 72'(outstanding), 72'(0));
        checkOutput("rst cmd_count",  72'(cmd_count), 72'(0));
        checkOutput("rst sts_count",  72'(sts_count), 72'(0));
        checkErr("rst", 1'b0, 8'h00);
        checkOutput("m_tlast", 72'(m_axis_cmd_tlast), 72'(1));
        tick();
        resetn = 1'b1;

        // cmdV cmdI mRdy stsV stsD | sRdy mV di tag out cc sc
        vecs.push_back(mk(1, 0, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 1, 0, 8'h00, 1, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 1, 2, 2, 2, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 3, 3, 0));
        vecs.push_back(mk(1, 3, 1, 0, 8'h00, 1, 0, 0, 0, 3, 3, 0));
        vecs.push_back(mk(1, 4, 1, 0, 8'h00, 0, 1, 3, 3, 3, 3, 0));
        vecs.push_back(mk(1, 4, 1, 0, 8'h00, 0, 0, 0, 0, 4, 4, 0));
        vecs.push_back(mk(1, 4, 1, 0, 8'h00, 0, 0, 0, 0, 4, 4, 0));
        vecs.push_back(mk(1, 4, 1, 1, 8'h80, 0, 0, 0, 0, 4, 4, 0));
        vecs.push_back(mk(1, 4, 1, 0, 8'h00, 1, 0, 0, 0, 3, 4, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 1, 4, 4, 3, 4, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 4, 5, 1));
        vecs.push_back(mk(0, 0, 1, 1, 8'h81, 0, 0, 0, 0, 4, 5, 1));
        vecs.push_back(mk(0, 0, 1, 1, 8'h82, 1, 0, 0, 0, 3, 5, 2));
        vecs.push_back(mk(0, 0, 1, 1, 8'h83, 1, 0, 0, 0, 2, 5, 3));
        vecs.push_back(mk(0, 0, 1, 1, 8'h84, 1, 0, 0, 0, 1, 5, 4));
        vecs.push_back(mk(1, 5, 0, 0, 8'h00, 1, 0, 0, 0, 0, 5, 5));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 6, 0, 0, 8'h00, 0, 1, 5, 5, 0, 5, 5));
        vecs.push_back(mk(1, 6, 1, 0, 8'h00, 1, 1, 5, 5, 0, 5, 5));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 1, 6, 6, 1, 6, 5));
        vecs.push_back(mk(0, 0, 1, 1, 8'h85, 1, 0, 0, 0, 2, 7, 5));
        vecs.push_back(mk(0, 0, 1, 1, 8'h86, 1, 0, 0, 0, 1, 7, 6));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 0, 7, 7));
        vecs.push_back(mk(1, 7, 1, 0, 8'h00, 1, 0, 0, 0, 0, 7, 7));
        vecs.push_back(mk(1, 8, 1, 0, 8'h00, 1, 1, 7, 7, 0, 7, 7));
        vecs.push_back(mk(0, 0, 1, 1, 8'h87, 1, 1, 8, 8, 1, 8, 7));
        vecs.push_back(mk(0, 0, 1, 1, 8'h88, 1, 0, 0, 0, 1, 9, 8));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 0, 9, 9));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].cmdV, cmdWord(vecs[i].cmdI), vecs[i].mRdy,
                          vecs[i].stsV, vecs[i].stsD, 1'b0);
            checkOutput($sformatf("v%0d s_tready", i), 72'(s_axis_cmd_tready), 72'(vecs[i].eSRdy));
            checkOutput($sformatf("v%0d sts_tready", i), 72'(s_axis_sts_tready), 72'(1));
            checkOutput($sformatf("v%0d m_tvalid", i), 72'(m_axis_cmd_tvalid), 72'(vecs[i].eMV));
            if (vecs[i].eMV)
                checkOutput($sformatf("v%0d m_tdata", i), m_axis_cmd_tdata,
                            expWord(vecs[i].eDi, vecs[i].eTag));
            checkOutput($sformatf("v%0d outstanding", i), 72'(outstanding), 72'(vecs[i].eOut));
            checkOutput($sformatf("v%0d cmd_count", i), 72'(cmd_count), 72'(vecs[i].eCc));
            checkOutput($sformatf("v%0d sts_count", i), 72'(sts_count), 72'(vecs[i].eSc));
            checkErr($sformatf("v%0d", i), 1'b0, 8'h00);
            tick();
        end

        // Clear the statistics, then 20 command/status pairs across the tag wrap.
        tagM = 4'd9;
        expM = 4'd9;
        applyStimulus(1'b1, cmdWord(99), 1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("clr s_tready", 72'(s_axis_cmd_tready), 72'(0));
        tick();
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("clr cmd_count", 72'(cmd_count), 72'(0));
        checkOutput("clr sts_count", 72'(sts_count), 72'(0));
        tick();
        for (int k = 0; k < 20; k++) begin
            issueCmd(100 + k);
            applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
            checkOutput($sformatf("pair%0d outstanding", k), 72'(outstanding), 72'(1));
            returnSts({4'h8, expM});
            expM = expM + 4'd1;
        end
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("pairs outstanding", 72'(outstanding), 72'(0));
        checkOutput("pairs cmd_count", 72'(cmd_count), 72'(20));
        checkOutput("pairs sts_count", 72'(sts_count), 72'(20));
        checkErr("pairs", 1'b0, 8'h00);
        tick();

        // SLVERR status latches, a later bad status does not overwrite it.
        issueCmd(200);
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b1, 8'hC0, 1'b0);
        checkOutput("slv outstanding", 72'(outstanding), 72'(1));
        checkErr("slv pre", 1'b0, 8'h00);
        tick();
        expM = expM + 4'd1;
        applyStimulus(1'b1, cmdWord(201), 1'b1, 1'b0, 8'h00, 1'b0);
        checkErr("slv", 1'b1, 8'hC0);
        checkOutput("slv s_tready", 72'(s_axis_cmd_tready), 72'(0));
        checkOutput("slv outstanding0", 72'(outstanding), 72'(0));
        checkOutput("slv sts_count", 72'(sts_count), 72'(21));
        tick();
        applyStimulus(1'b1, cmdWord(201), 1'b1, 1'b1, 8'h85, 1'b0);
        checkOutput("slv2 s_tready", 72'(s_axis_cmd_tready), 72'(0));
        tick();
        applyStimulus(1'b1, cmdWord(201), 1'b1, 1'b0, 8'h00, 1'b0);
        checkErr("slv2", 1'b1, 8'hC0);
        checkOutput("slv2 sts_count", 72'(sts_count), 72'(22));
        checkOutput("slv2 cmd_count", 72'(cmd_count), 72'(21));
        checkOutput("slv2 outstanding", 72'(outstanding), 72'(0));
        checkOutput("slv2 m_tvalid", 72'(m_axis_cmd_tvalid), 72'(0));
        tick();
        applyStimulus(1'b1, cmdWord(201), 1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("clr2 s_tready", 72'(s_axis_cmd_tready), 72'(0));
        tick();
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkErr("clr2", 1'b0, 8'h00);
        checkOutput("clr2 cmd_count", 72'(cmd_count), 72'(0));
        checkOutput("clr2 sts_count", 72'(sts_count), 72'(0));
        checkOutput("clr2 s_tready idle", 72'(s_axis_cmd_tready), 72'(1));
        tick();

        // Flow resumes with the tag sequence intact; walk expected tag to 1.
        issueCmd(201);
        returnSts({4'h8, expM});
        expM = expM + 4'd1;
        issueCmd(202);
        returnSts({4'h8, expM});
        expM = expM + 4'd1;
        issueCmd(203);
        returnSts({4'h8, expM});
        expM = expM + 4'd1;
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkErr("resume", 1'b0, 8'h00);
        checkOutput("resume outstanding", 72'(outstanding), 72'(0));
        tick();

        // Tag mismatch: expected 1, received 3.
        issueCmd(204);
        returnSts(8'h83);
        expM = expM + 4'd1;
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkErr("mismatch", 1'b1, 8'h83);
        checkOutput("mismatch outstanding", 72'(outstanding), 72'(0));
        tick();
        returnSts(8'h80);
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkErr("mismatch hold", 1'b1, 8'h83);
        checkOutput("mismatch hold outstanding", 72'(outstanding), 72'(0));
        tick();
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();

        // Status with nothing outstanding on a clean flag gives a protocol error.
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b1, {4'h8, expM}, 1'b0);
        checkErr("orphan pre", 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkErr("orphan", 1'b1, 8'hFF);
        checkOutput("orphan outstanding", 72'(outstanding), 72'(0));
        tick();
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();

        // The orphan status must not have advanced the expected tag.
        issueCmd(205);
        returnSts({4'h8, expM});
        applyStimulus(1'b0, 72'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkErr("final", 1'b0, 8'h00);
        checkOutput("final outstanding", 72'(outstanding), 72'(0));
        checkOutput("final sts_count", 72'(sts_count), 72'(1));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/axis_mm2s_cmd_throttle.md
# axis_mm2s_cmd_throttle

Sits between the MM2S command generator and the AXI DataMover MM2S command/status ports. Forwards 72-bit DataMover commands through a one-deep register slice and stamps each with a rolling 4-bit tag. It limits commands in flight to a programmable credit, consumes the MM2S status stream and checks its tags, and halts command flow on the first error until software clears it.

## Interface
Parameters:
- MAX_OUTSTANDING, 4, maximum commands issued to the DataMover without returned status; legal range 1..8.
- OUT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- s_axis_cmd_tdata  in  72  command from the generator.
- s_axis_cmd_tvalid  in  1  command valid.
- s_axis_cmd_tready  out  1  command accepted.
- s_axis_cmd_tlast  in  1  ignored.
- m_axis_cmd_tdata  out  72  command to the DataMover; bits [67:64] replaced by the tag.
- m_axis_cmd_tvalid  out  1  command valid.
- m_axis_cmd_tready  in  1  DataMover accepts.
- m_axis_cmd_tlast  out  1  constant 1.
- s_axis_sts_tdata  in  8  status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG.
- s_axis_sts_tvalid  in  1  status valid.
- s_axis_sts_tready  out  1  constant 1 out of reset, 0 during reset.
- clear  in  1  synchronous soft clear of error and statistics.
- outstanding  out  OUT_W  commands issued without returned status.
- cmd_count  out  32  commands issued on m side.
- sts_count  out  32  statuses received.
- err_flag  out  1  sticky error; halts command flow.
- err_code  out  8  status byte of the first error, or 8'hFF for a protocol error.

## Operation
- Handshakes:
  - s_hs = s_axis_cmd_tvalid & s_axis_cmd_tready.
  - m_hs = m_axis_cmd_tvalid & m_axis_cmd_tready.
  - st_hs = s_axis_sts_tvalid & s_axis_sts_tready.
- s_axis_cmd_tready = resetn & !err_flag & (!m_axis_cmd_tvalid | m_axis_cmd_tready) & (outstanding + m_axis_cmd_tvalid < MAX_OUTSTANDING). This is combinational.
- On s_hs:
  - m_axis_cmd_tdata <= {s_tdata[71:68], tag, s_tdata[63:0]}.
  - m_axis_cmd_tvalid <= 1.
  - tag <= tag + 1 (4-bit wrap, 15 -> 0).
- On m_hs without s_hs: m_axis_cmd_tvalid <= 0. The data holds and is stable while valid & !ready.
- On m_hs, cmd_count increments (32-bit wrap).
- Outstanding counter:
  - +1 on m_hs.
  - -1 on a valid st_hs.
  - m_hs and st_hs in the same cycle leave it unchanged.
- Status check on st_hs, using exp_tag (oldest expected tag, starts at 0):
  - sts_count increments and exp_tag increments.
  - If outstanding == 0 (no matching command), this is a protocol error: err_code = 8'hFF, the counter does not decrement, and exp_tag does not advance.
  - Otherwise, an error is flagged if [7]==0, any of [6:4]==1, or [3:0] != exp_tag. In that case err_code = status byte.
- Errors:
  - err_flag is sticky; err_code holds the first error only.
  - While err_flag is set, s_tready = 0. A command already in the slice still drains. Status is still consumed and counted.
- clear (priority below resetn):
  - Zeroes err_flag, err_code, cmd_count and sts_count.
  - Does not touch tag, exp_tag, outstanding or the slice contents, so in-flight statuses still match.
  - s_tready is forced 0 in the clear cycle.
- Reset values:
  - m_axis_cmd_tvalid = 0, m_axis_cmd_tdata = 0.
  - tag = 0, exp_tag = 0, outstanding = 0.
  - cmd_count = 0, sts_count = 0.
  - err_flag = 0, err_code = 0.
  - s_axis_sts_tready = 0, s_axis_cmd_tready = 0.

## Timing
- Latency: s_hs in cycle N gives m_axis_cmd_tvalid = 1 in cycle N+1.
- Full throughput of one command per cycle when m_tready = 1 and credit is available.
- Credit:
  - A status returned in cycle N frees credit for s_tready in cycle N+1. Credit is not applied in the same cycle.
  - At outstanding + m_tvalid == MAX_OUTSTANDING, s_tready is 0.
- An error detected on st_hs in cycle N gives err_flag = 1 and s_tready = 0 from cycle N+1.
- Statistics and outstanding update on the clock edge following the handshake.

## Test plan
- Reset, then feed 3 commands with m_tready = 1 -> out tags 0, 1, 2; bits [63:0] unchanged; cmd_count = 3; outstanding = 3.
- MAX_OUTSTANDING = 4, no status, 6 commands offered -> exactly 4 forwarded and s_tready stays 0. One OK status with tag 0 -> a 5th command is accepted one cycle later.
- 20 command/status pairs with status 8'h80|tag -> tags wrap 15 -> 0; no error; outstanding ends at 0; sts_count = 20.
- m_tready held low for 5 cycles -> m_tdata and m_tvalid stable; no second command accepted.
- Status 8'hC0 (SLVERR, tag 0) -> err_flag = 1, err_code = 8'hC0, s_tready = 0. A second bad status leaves err_code at 8'hC0. Pulse clear -> flag and counters zero, flow resumes, tag continues.
- Status tag mismatch (expected 1, received 3), then a status with outstanding = 0 -> err_code = 8'h83. Separately, a status with nothing outstanding gives 8'hFF and outstanding stays 0. Same-cycle m_hs and st_hs -> outstanding unchanged.
